// File: rtl/pulse_train_ctrl.sv
// Pulse-train controller: drives an external time base through ON/OFF phases
// for a latched number of periods, with a watchdog against a stuck time base.
module pulse_train_ctrl #(
    parameter int n = 8,
    parameter int m = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] t_on,
    input  logic [n-1:0] t_off,
    input  logic [m-1:0] n_pulses,
    input  logic         eoBT,
    output logic         stBT,
    output logic [n-1:0] dat,
    output logic         pulse,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    // Last watchdog value allowed inside a phase; one more cycle means timeout.
    localparam logic [n:0] WD_LAST = {1'b1, {n{1'b0}}};

    state_t       state, state_nx;
    logic [n-1:0] on_lat, off_lat;
    logic [m-1:0] np_lat;
    logic [m-1:0] per_cnt, per_nx, per_inc;
    logic [n:0]   wd, wd_nx;
    logic [n-1:0] dat_nx;
    logic         latch;
    logic         done_nx, err_nx;

    assign per_inc = per_cnt + m'(1);

    always_comb begin
        state_nx = state;
        per_nx   = per_cnt;
        wd_nx    = wd;
        dat_nx   = dat;
        latch    = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                wd_nx = '0;
                if (start) begin
                    if (n_pulses != '0) begin
                        latch    = 1'b1;
                        per_nx   = '0;
                        dat_nx   = t_on;
                        state_nx = ON;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ON: begin
                if (eoBT) begin
                    state_nx = OFF;
                    wd_nx    = '0;
                    dat_nx   = off_lat;
                end else if (wd == WD_LAST) begin
                    state_nx = IDLE;
                    wd_nx    = '0;
                    err_nx   = 1'b1;
                end else begin
                    wd_nx = wd + (n+1)'(1);
                end
            end
            OFF: begin
                if (eoBT) begin
                    wd_nx  = '0;
                    per_nx = per_inc;
                    if (per_inc == np_lat) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = ON;
                        dat_nx   = on_lat;
                    end
                end else if (wd == WD_LAST) begin
                    state_nx = IDLE;
                    wd_nx    = '0;
                    err_nx   = 1'b1;
                end else begin
                    wd_nx = wd + (n+1)'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                wd_nx    = '0;
            end
        endcase
    end

    // Outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            on_lat  <= '0;
            off_lat <= '0;
            np_lat  <= '0;
            per_cnt <= '0;
            wd      <= '0;
            dat     <= '0;
            stBT    <= 1'b0;
            pulse   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            per_cnt <= per_nx;
            wd      <= wd_nx;
            dat     <= dat_nx;
            stBT    <= (state_nx != IDLE);
            pulse   <= (state_nx == ON);
            busy    <= (state_nx != IDLE);
            done    <= done_nx;
            err     <= err_nx;
            if (latch) begin
                on_lat  <= t_on;
                off_lat <= t_off;
                np_lat  <= n_pulses;
            end
        end
    end

endmodule

// File: doc/pulse_train_ctrl.md
PULSE_TRAIN_CTRL -- requirements
Module: pulse_train_ctrl

Interface
REQ-001 Parameter n, default 8, width of the time-base compare value and interval fields.
REQ-002 Parameter m, default 8, width of the pulse-count field.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 start  input  1  request a pulse train; sampled only in IDLE.
REQ-006 t_on  input  n  high-phase compare value; phase lasts t_on+1 cycles.
REQ-007 t_off  input  n  low-phase compare value; phase lasts t_off+1 cycles.
REQ-008 n_pulses  input  m  number of on/off periods to generate; 0 is illegal.
REQ-009 eoBT  input  1  end-of-interval from the time-base counter; high when its count equals dat.
REQ-010 stBT  output  1  time-base enable; time base counts while high.
REQ-011 dat  output  n  compare value presented to the time base.
REQ-012 pulse  output  1  generated pulse-train waveform.
REQ-013 busy  output  1  high in ON and OFF states.
REQ-014 done  output  1  one-cycle strobe on normal train completion.
REQ-015 err  output  1  one-cycle strobe on rejected start or watchdog timeout.

Function
REQ-016 The FSM SHALL have states IDLE, ON, OFF; all outputs SHALL be registered.
REQ-017 In IDLE with start=1 and n_pulses!=0, the block SHALL latch t_on, t_off, n_pulses, clear the period counter, and enter ON next edge.
REQ-018 In IDLE with start=1 and n_pulses=0, the block SHALL pulse err for one cycle and remain in IDLE.
REQ-019 start in ON or OFF SHALL be ignored; input changes after latch SHALL not affect the running train.
REQ-020 In ON: pulse=1, stBT=1, dat=latched t_on; in OFF: pulse=0, stBT=1, dat=latched t_off; in IDLE: pulse=0, stBT=0, dat held.
REQ-021 In ON, eoBT=1 SHALL move the FSM to OFF at the next edge, with dat switching to t_off on the same edge (time base self-clears on match).
REQ-022 In OFF, eoBT=1 SHALL increment the period counter; if the count reaches latched n_pulses the FSM SHALL go to IDLE and pulse done, else return to ON.
REQ-023 The rising edge of pulse SHALL occur one cycle after start sampled; stBT and pulse rise together.
REQ-024 eoBT SHALL be ignored in IDLE.
REQ-025 A watchdog of width n+1 SHALL clear on every phase entry and increment each cycle in ON/OFF; reaching 2^n+1 without eoBT SHALL force IDLE, stBT=0, pulse=0 and pulse err.
REQ-026 t_on=0 or t_off=0 SHALL be legal and yield a one-cycle phase.
REQ-027 done and err SHALL never assert in the same cycle.
REQ-028 The time base SHALL be reset from the same reset source so its count is 0 whenever this block leaves reset.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, stBT=0, dat=0, pulse=0, busy=0, done=0, err=0, period counter and watchdog 0, including mid-train.
REQ-030 After rst returns to 1, the first start SHALL be accepted normally.

Verification
REQ-031 t_on=3, t_off=2, n_pulses=2, start 1 cycle -> pulse 1 for 4 cycles, 0 for 3, 1 for 4, 0 for 3; done one cycle after last OFF; busy high 14 cycles.
REQ-032 n_pulses=0, start -> err one cycle, busy/stBT stay 0.
REQ-033 t_on=0, t_off=0, n_pulses=3 -> pulse toggles every cycle 1,0,1,0,1,0; then done.
REQ-034 Running train, assert start and change t_on mid-train -> waveform unchanged, no err.
REQ-035 Model time base with eoBT tied 0, n=8 -> err after 257 cycles in ON, pulse/stBT drop to 0.
REQ-036 rst=0 asserted during OFF of 3rd pulse -> all outputs 0 asynchronously; new start after release yields full train.
